// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, grant and request types for the memory port arbiter
package mem_arb_pkg;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W = ARB_DATA_W / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;
  typedef struct packed {
    logic                  we;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and backend signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_req;
  logic              d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              m_req;
  logic              m_we;
  logic [DATA_W/8-1:0] m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;
  logic              bus_err;
  modport master (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_be, m_addr, m_wdata, bus_err
  );
  modport slave (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_be, m_addr, m_wdata, bus_err
  );
endinterface

// File: rtl/arb_wait_timer.sv
// arb_wait_timer: counts backend wait cycles and flags when MAX_WAIT is reached
module arb_wait_timer #(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = $clog2(MAX_WAIT + 1);
  logic [W-1:0] r_cnt;
  assign o_expired = r_cnt == W'(MAX_WAIT);
  // count stalled cycles, holding at the limit until the response cycle clears it
  always_ff @(posedge clk)
    r_cnt <= (reset || i_clear) ? '0 : (i_enable && !o_expired) ? r_cnt + W'(1) : r_cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store; define ARB_RR_EN for round-robin ties
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int MAX_WAIT = 255
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.master bus
);
  localparam int BE_W = DATA_W / 8;
  state_t r_state, w_next;
  grant_t r_gnt, w_gnt;
  req_t r_req, w_req;
  logic r_err;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
  logic w_issue, w_done, w_timeout, w_expired;
  assign w_issue   = r_state == IDLE && (bus.i_req || bus.d_req);
  assign w_done    = r_state == WAIT && bus.m_ack;
  assign w_timeout = r_state == WAIT && !bus.m_ack && w_expired;
`ifdef ARB_RR_EN
  grant_t r_last;
  assign w_gnt = (bus.i_req && bus.d_req) ? (r_last == GNT_D ? GNT_I : GNT_D) : (bus.d_req ? GNT_D : GNT_I);
  // remember the last winner so the other requester takes the next tie
  always_ff @(posedge clk)
    r_last <= reset ? GNT_I : w_issue ? w_gnt : r_last;
`else
  assign w_gnt = bus.d_req ? GNT_D : GNT_I;
`endif
  assign w_req = w_gnt == GNT_D
    ? req_t'{we: bus.d_we, be: ARB_BE_W'(bus.d_be), addr: ARB_ADDR_W'(bus.d_addr), wdata: ARB_DATA_W'(bus.d_wdata)}
    : req_t'{we: 1'b0, be: '1, addr: ARB_ADDR_W'(bus.i_addr), wdata: '0};
  arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk),
    .reset(reset),
    .i_clear(r_state == RESP),
    .i_enable(r_state == WAIT && !bus.m_ack),
    .o_expired(w_expired)
  );
  // state register
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  // next state: one transaction at a time, response lasts exactly one cycle
  always_comb
    w_next = r_state == IDLE ? ((bus.i_req || bus.d_req) ? WAIT : IDLE)
           : r_state == WAIT ? ((bus.m_ack || w_expired) ? RESP : WAIT) : IDLE;
  // handshake outputs decoded from state and the latched grant
  always_comb begin
    bus.m_req   = r_state == WAIT;
    bus.i_ack   = r_state == RESP && r_gnt == GNT_I;
    bus.d_ack   = r_state == RESP && r_gnt == GNT_D;
    bus.bus_err = r_state == RESP && r_err;
  end
  // latch the winning request on issue; capture read data, or zero it on timeout
  always_ff @(posedge clk)
    if (reset) begin
      r_req     <= '0;
      r_gnt     <= GNT_I;
      r_err     <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_issue) begin
        r_req <= w_req;
        r_gnt <= w_gnt;
      end
      if ((w_done || w_timeout) && r_gnt == GNT_I) r_i_rdata <= w_done ? bus.m_rdata : '0;
      if ((w_done || w_timeout) && r_gnt == GNT_D) r_d_rdata <= w_done ? bus.m_rdata : '0;
      r_err <= w_timeout || (r_err && r_state != RESP);
    end
  assign bus.m_we    = r_req.we;
  assign bus.m_be    = r_req.be[BE_W-1:0];
  assign bus.m_addr  = r_req.addr[ADDR_W-1:0];
  assign bus.m_wdata = r_req.wdata[DATA_W-1:0];
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus scoreboard for the shared memory port arbiter
module tb_mem_port_arbiter;
  localparam int MAXW = 4;
  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          delay;
    logic        err;
    logic [31:0] rdata;
  } txn_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_i = '0;
  logic [31:0] exp_d = '0;
  bit last_d = 1'b0;
  txn_t sb[$];
  txn_t vecs[7];
  txn_t t_i, t_d, t_r;
  bit d_first;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic issue(input txn_t e);
    if (e.is_d) begin
      bus.d_req = 1'b1;
      bus.d_we = e.we;
      bus.d_be = e.be;
      bus.d_addr = e.addr;
      bus.d_wdata = e.wdata;
    end else begin
      bus.i_req = 1'b1;
      bus.i_addr = e.addr;
    end
  endtask
  task automatic push(input txn_t e);
    sb.push_back(e);
    last_d = e.is_d;
  endtask
  task automatic serve();
    int c = 0;
    int mreq = 0;
    int first = 0;
    int last = 0;
    int exp_start = 1;
    txn_t e;
    while (sb.size() > 0 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
      bus.m_ack = 1'b0;
      bus.m_rdata = $urandom;
      if (bus.i_ack || bus.d_ack) begin
        e = sb.pop_front();
        chk("ack_d", 32'(bus.d_ack), 32'(e.is_d));
        chk("ack_i", 32'(bus.i_ack), 32'(!e.is_d));
        chk("bus_err", 32'(bus.bus_err), 32'(e.err));
        if (e.is_d) exp_d = e.rdata;
        else exp_i = e.rdata;
        chk("i_rdata", bus.i_rdata, exp_i);
        chk("d_rdata", bus.d_rdata, exp_d);
        chk("m_req_cycles", 32'(mreq), 32'((e.delay < MAXW ? e.delay : MAXW) + 1));
        chk("m_req_start", 32'(first), 32'(exp_start));
        chk("ack_latency", 32'(c), 32'(last + 1));
        exp_start = c + 2;
        mreq = 0;
        if (e.is_d) bus.d_req = 1'b0;
        else bus.i_req = 1'b0;
      end else begin
        chk("bus_err_alone", 32'(bus.bus_err), 32'(0));
        if (bus.m_req) begin
          if (mreq == 0) first = c;
          mreq++;
          last = c;
          chk("m_we", 32'(bus.m_we), 32'(sb[0].we));
          chk("m_be", 32'(bus.m_be), 32'(sb[0].be));
          chk("m_addr", bus.m_addr, sb[0].addr);
          if (sb[0].is_d) chk("m_wdata", bus.m_wdata, sb[0].wdata);
          if (sb[0].delay <= MAXW && mreq == sb[0].delay + 1) begin
            bus.m_ack = 1'b1;
            bus.m_rdata = sb[0].mrdata;
          end
        end
      end
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL serve_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
    bus.m_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_m_req", 32'(bus.m_req), 32'(0));
    chk("idle_acks", 32'({bus.i_ack, bus.d_ack, bus.bus_err}), 32'(0));
  endtask
  initial begin
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_be = '0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.m_rdata = '0;
    bus.m_ack = 1'b0;
    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h8000_0000, 32'h0, 32'h2408_0001, 2, 1'b0, 32'h2408_0001};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h1000_0010, 32'hDEAD_BEEF, 32'h1111_2222, 0, 1'b0, 32'h1111_2222};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h1000_0020, 32'h0, 32'hCAFE_0001, 1, 1'b0, 32'hCAFE_0001};
    vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h1000_0030, 32'h0, 32'h5555_AAAA, 99, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 4'hF, 32'h8000_0004, 32'h0, 32'h1234_5678, MAXW, 1'b0, 32'h1234_5678};
    vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h8000_0008, 32'h0, 32'h7777_7777, 99, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 4'hC, 32'h1000_0050, 32'h0, 32'hA5A5_0F0F, 3, 1'b0, 32'hA5A5_0F0F};
    t_i = '{1'b0, 1'b0, 4'hF, 32'h8000_0100, 32'h0, 32'h1357_9BDF, 1, 1'b0, 32'h1357_9BDF};
    t_d = '{1'b1, 1'b1, 4'h5, 32'h1000_0040, 32'h0BAD_F00D, 32'h2468_ACE0, 2, 1'b0, 32'h2468_ACE0};
    t_r = '{1'b0, 1'b0, 4'hF, 32'h8000_0200, 32'h0, 32'h0F0F_1234, 1, 1'b0, 32'h0F0F_1234};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req", 32'(bus.m_req), 32'(0));
    chk("rst_m_we", 32'(bus.m_we), 32'(0));
    chk("rst_m_be", 32'(bus.m_be), 32'(0));
    chk("rst_m_addr", bus.m_addr, 32'h0);
    chk("rst_m_wdata", bus.m_wdata, 32'h0);
    chk("rst_acks", 32'({bus.i_ack, bus.d_ack, bus.bus_err}), 32'(0));
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      issue(vecs[k]);
      push(vecs[k]);
      serve();
    end
    @(negedge clk);
    issue(t_i);
    issue(t_d);
`ifdef ARB_RR_EN
    d_first = !last_d;
`else
    d_first = 1'b1;
`endif
    if (d_first) begin
      push(t_d);
      push(t_i);
    end else begin
      push(t_i);
      push(t_d);
    end
    serve();
    @(negedge clk);
    issue(t_r);
    @(posedge clk);
    #1;
    chk("mid_m_req", 32'(bus.m_req), 32'(1));
    @(negedge clk);
    reset = 1'b1;
    bus.i_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_wait_m_req", 32'(bus.m_req), 32'(0));
    chk("rst_wait_acks", 32'({bus.i_ack, bus.d_ack}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    exp_i = '0;
    exp_d = '0;
    last_d = 1'b0;
    bus.m_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("stray_ack_m_req", 32'(bus.m_req), 32'(0));
      chk("stray_ack_acks", 32'({bus.i_ack, bus.d_ack, bus.bus_err}), 32'(0));
    end
    chk("post_rst_i_rdata", bus.i_rdata, 32'h0);
    bus.m_ack = 1'b0;
    @(negedge clk);
    issue(t_r);
    push(t_r);
    serve();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
